// File: rtl/apb_master_bridge_pkg.sv
// Shared types and address-map constants for the CPU-to-APB4 bridge.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_BASE       = 32'h1000_0000;
  localparam int          SLAVE_WIN_BITS = 12;
  localparam int          MAX_SLAVES     = 8;
  localparam int          IDX_W          = 3;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB4 bus bundle between the bridge (master) and the peripherals (slave).
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  logic [31:0]              PADDR;
  logic                     PWRITE;
  logic [31:0]              PWDATA;
  logic [3:0]               PSTRB;
  logic                     PENABLE;
  logic [NUM_SLAVES-1:0]    PSEL;
  logic [32*NUM_SLAVES-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;
  logic [NUM_SLAVES-1:0]    PSLVERR;

  modport master (
    output PADDR, PWRITE, PWDATA, PSTRB, PENABLE, PSEL,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PSTRB, PENABLE, PSEL,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational address decode: one 4 KiB window per slave starting at APB_BASE.
module apb_addr_decoder
  import apb_master_bridge_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);
  localparam int PG_W = 32 - SLAVE_WIN_BITS;

  logic [PG_W-1:0] page_ofs;

  // Below-base addresses wrap to huge offsets, but the explicit >= guards that too.
  assign page_ofs = addr_i[31:SLAVE_WIN_BITS] - APB_BASE[31:SLAVE_WIN_BITS];
  assign hit_o    = (addr_i >= APB_BASE) && (page_ofs < PG_W'(NUM_SLAVES));
  assign idx_o    = page_ofs[IDX_W-1:0];
endmodule

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB4 bridge: SETUP/ACCESS FSM, request latches, PREADY timeout.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                transfer_i,
  input  logic                write_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          wstrb_i,
  output logic [31:0]         rdata_o,
  output logic                ready_o,
  output logic                err_o,
  apb_master_bridge_if.master apb
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e       state_q, state_d;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  logic             write_q, ready_q, err_q;
  logic [IDX_W-1:0] idx_q;
  logic [CW-1:0]    cnt_q;

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             sel_ready, sel_err, timeout_hit, accept, done;
  logic [31:0]      sel_rdata;
  logic [NUM_SLAVES-1:0] psel_c;
  logic             penable_c;

  apb_addr_decoder #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
    .addr_i (addr_i),
    .hit_o  (hit),
    .idx_o  (idx)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        sel_ready = apb.PREADY[n];
        sel_err   = apb.PSLVERR[n];
        sel_rdata = apb.PRDATA[32*n +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign accept      = (state_q == IDLE) && transfer_i;
  assign done        = (state_q == ACCESS) && (sel_ready || timeout_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && hit) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_c    = '0;
    penable_c = 1'b0;
    if (state_q != IDLE) begin
      for (int n = 0; n < NUM_SLAVES; n++) psel_c[n] = (idx_q == IDX_W'(n));
      penable_c = (state_q == ACCESS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
        write_q <= write_i;
        idx_q   <= idx;
      end
      if (state_d == SETUP) cnt_q <= '0;
      else if (state_q == ACCESS && !sel_ready && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      ready_q <= (accept && !hit) || done;
      // PREADY wins over a coincident timeout; a timeout alone is always an error.
      err_q   <= (accept && !hit) || (done && (!sel_ready || sel_err));
      if (accept && !hit) rdata_q <= '0;
      else if (done)      rdata_q <= (sel_ready && !write_q) ? sel_rdata : 32'h0;
    end
  end

  assign apb.PSEL    = psel_c;
  assign apb.PENABLE = penable_c;
  assign apb.PADDR   = addr_q;
  assign apb.PWRITE  = write_q;
  assign apb.PWDATA  = wdata_q;
  assign apb.PSTRB   = write_q ? wstrb_q : 4'b0;

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;
endmodule
